// File: rtl/qp_mem_arbiter.sv
// Arbiter for port 0 of the query-patch SRAM between the Wishbone controller (W)
// and the query-fetch engine (A). Optional grant/conflict counters: QP_ARB_STATS_EN.
module qp_mem_arbiter #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int ADDRW      = $clog2(NUM_QUERYS),
    parameter int PW         = PATCH_SIZE * DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debug_mode,
    input  logic             w_req,
    input  logic             w_we,
    input  logic             w_lock,
    input  logic [ADDRW-1:0] w_addr,
    input  logic [PW-1:0]    w_wdata,
    output logic             w_gnt,
    output logic             w_rvalid,
    output logic [PW-1:0]    w_rdata,
    input  logic             a_req,
    input  logic             a_we,
    input  logic             a_lock,
    input  logic [ADDRW-1:0] a_addr,
    input  logic [PW-1:0]    a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [PW-1:0]    a_rdata,
    output logic             mem_csb0,
    output logic             mem_web0,
    output logic [ADDRW-1:0] mem_addr0,
    output logic [PW-1:0]    mem_wpatch0,
    input  logic [PW-1:0]    mem_rpatch0,
    output logic             busy
`ifdef QP_ARB_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      w_grant_cnt,
    output logic [15:0]      a_grant_cnt,
    output logic [15:0]      conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LOCK_W = 2'd1,
        LOCK_A = 2'd2
    } state_e;

    localparam logic OWN_W = 1'b0;
    localparam logic OWN_A = 1'b1;

    state_e          state_q, state_d;
    logic            rr_last_q;
    logic            debug_q;
    logic            w_rvalid_q, a_rvalid_q;
    logic [PW-1:0]   w_rdata_q, a_rdata_q;
    logic            w_win_s, a_win_s;

    // State, round-robin pointer and read-return registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FREE;
            rr_last_q  <= OWN_A;
            debug_q    <= 1'b0;
            w_rvalid_q <= 1'b0;
            a_rvalid_q <= 1'b0;
            w_rdata_q  <= '0;
            a_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            debug_q    <= debug_mode;
            w_rvalid_q <= w_win_s & ~w_we;
            a_rvalid_q <= a_win_s & ~a_we;
            if (w_win_s) begin
                rr_last_q <= OWN_W;
            end else if (a_win_s) begin
                rr_last_q <= OWN_A;
            end else begin
                rr_last_q <= rr_last_q;
            end
            if (w_rvalid_q) begin
                w_rdata_q <= mem_rpatch0;
            end else begin
                w_rdata_q <= w_rdata_q;
            end
            if (a_rvalid_q) begin
                a_rdata_q <= mem_rpatch0;
            end else begin
                a_rdata_q <= a_rdata_q;
            end
        end
    end

    // Next-state: locks persist until the owner's unlocked access; a debug rising edge breaks an A lock
    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE: begin
                if (w_win_s && w_lock) begin
                    state_d = LOCK_W;
                end else if (a_win_s && a_lock) begin
                    state_d = LOCK_A;
                end else begin
                    state_d = FREE;
                end
            end
            LOCK_W: begin
                if (w_win_s && !w_lock) begin
                    state_d = FREE;
                end else begin
                    state_d = LOCK_W;
                end
            end
            LOCK_A: begin
                if (debug_mode && !debug_q) begin
                    state_d = FREE;
                end else if (a_win_s && !a_lock) begin
                    state_d = FREE;
                end else begin
                    state_d = LOCK_A;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // Winner selection; nothing is granted while reset is asserted
    always_comb begin
        w_win_s = 1'b0;
        a_win_s = 1'b0;
        if (!rst_n) begin
            w_win_s = 1'b0;
            a_win_s = 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    if (debug_mode) begin
                        w_win_s = w_req;
                        a_win_s = a_req & ~w_req;
                    end else if (w_req && a_req) begin
                        w_win_s = (rr_last_q == OWN_A);
                        a_win_s = (rr_last_q == OWN_W);
                    end else begin
                        w_win_s = w_req;
                        a_win_s = a_req;
                    end
                end
                LOCK_W:  w_win_s = w_req;
                LOCK_A:  a_win_s = a_req;
                default: begin
                    w_win_s = 1'b0;
                    a_win_s = 1'b0;
                end
            endcase
        end
    end

    // SRAM port driven straight from the winner
    always_comb begin
        mem_csb0    = 1'b1;
        mem_web0    = 1'b1;
        mem_addr0   = '0;
        mem_wpatch0 = '0;
        if (w_win_s) begin
            mem_csb0    = 1'b0;
            mem_web0    = ~w_we;
            mem_addr0   = w_addr;
            mem_wpatch0 = w_wdata;
        end else if (a_win_s) begin
            mem_csb0    = 1'b0;
            mem_web0    = ~a_we;
            mem_addr0   = a_addr;
            mem_wpatch0 = a_wdata;
        end else begin
            mem_csb0    = 1'b1;
            mem_web0    = 1'b1;
            mem_addr0   = '0;
            mem_wpatch0 = '0;
        end
    end

    assign w_gnt    = w_win_s;
    assign a_gnt    = a_win_s;
    assign w_rvalid = w_rvalid_q;
    assign a_rvalid = a_rvalid_q;
    // SRAM data arrives in the rvalid cycle itself; the register keeps it afterwards
    assign w_rdata  = w_rvalid_q ? mem_rpatch0 : w_rdata_q;
    assign a_rdata  = a_rvalid_q ? mem_rpatch0 : a_rdata_q;
    assign busy     = (state_q == LOCK_W) || (state_q == LOCK_A);

`ifdef QP_ARB_STATS_EN
    logic [15:0] w_cnt_q, a_cnt_q, c_cnt_q;

    // Saturating grant and conflict counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_cnt_q <= 16'h0000;
            a_cnt_q <= 16'h0000;
            c_cnt_q <= 16'h0000;
        end else if (stats_clr) begin
            w_cnt_q <= 16'h0000;
            a_cnt_q <= 16'h0000;
            c_cnt_q <= 16'h0000;
        end else begin
            if (w_win_s && (w_cnt_q != 16'hFFFF)) w_cnt_q <= w_cnt_q + 16'h0001;
            if (a_win_s && (a_cnt_q != 16'hFFFF)) a_cnt_q <= a_cnt_q + 16'h0001;
            if (w_req && a_req && (c_cnt_q != 16'hFFFF)) c_cnt_q <= c_cnt_q + 16'h0001;
        end
    end

    assign w_grant_cnt  = w_cnt_q;
    assign a_grant_cnt  = a_cnt_q;
    assign conflict_cnt = c_cnt_q;
`endif

endmodule
